// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO slice.
//   WIDTH  - default data word width in bits
//   DEPTH  - default number of entries (power of two)
//   word_t - one data word at the default width
package fifo_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;

    typedef logic [WIDTH-1:0] word_t;

endpackage : fifo_pkg

// File: rtl/fifo_if.sv
// Signal bundle the environment uses to drive and observe sync_fifo.
//   clk      - interface clock (port)
//   rst      - asynchronous active-high reset
//   rd, wr   - read / write requests
//   data_in  - write data
//   data_out - registered read data
//   empty    - FIFO holds no entries
//   full     - FIFO holds DEPTH entries
interface fifo_if (
    input logic clk
);
    import fifo_pkg::*;

    logic  rst;
    logic  rd;
    logic  wr;
    logic  empty;
    logic  full;
    word_t data_in;
    word_t data_out;

    modport dut (
        input  clk,
        input  rst,
        input  rd,
        input  wr,
        input  data_in,
        output data_out,
        output empty,
        output full
    );

    modport env (
        input  clk,
        output rst,
        output rd,
        output wr,
        output data_in,
        input  data_out,
        input  empty,
        input  full
    );

endinterface : fifo_if

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x WIDTH register array, one write port and one
// synchronous read port with a resettable output register.
//   clk   - clock
//   rst   - asynchronous active-high reset (clears rdata only)
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   re    - read enable
//   raddr - read address
//   rdata - registered read data, updates only when re is high
module sync_fifo_mem #(
    parameter int unsigned WIDTH = fifo_pkg::WIDTH,
    parameter int unsigned DEPTH = fifo_pkg::DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; pointers make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-edge read and write never alias: the write targets the tail while a
    // read is only accepted when the head holds a previously written word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock FIFO, DEPTH entries of WIDTH bits, registered read data and
// full/empty flags decoded from an occupancy register.
//   clk      - clock, all state updates on the rising edge
//   rd       - read request, accepted when not empty
//   wr       - write request, accepted when not full
//   empty    - occupancy is zero
//   full     - occupancy is DEPTH
//   data_in  - write data, sampled on an accepted write
//   data_out - read data, changes only on an accepted read
//   rst      - asynchronous active-high reset
module sync_fifo #(
    parameter int unsigned WIDTH = fifo_pkg::WIDTH,
    parameter int unsigned DEPTH = fifo_pkg::DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rd,
    input  logic             wr,
    output logic             empty,
    output logic             full,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    input  logic             rst
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q,  cnt_d;
    logic          wr_acc;
    logic          rd_acc;

    // Flags come straight from the count register: no path from rd/wr.
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_FULL);

    assign wr_acc = wr && !full;
    assign rd_acc = rd && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (wr_acc) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_acc) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wptr_q),
        .wdata (data_in),
        .re    (rd_acc),
        .raddr (rptr_q),
        .rdata (data_out)
    );

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic       empty;
    logic       full;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue of stored words plus last value read out.
    logic [7:0] q[$];
    logic [7:0] m_dout = 8'h00;

    always #5 clk = ~clk;

    sync_fifo dut (
        .clk      (clk),
        .rd       (rd),
        .wr       (wr),
        .empty    (empty),
        .full     (full),
        .data_in  (data_in),
        .data_out (data_out),
        .rst      (rst)
    );

    // Apply one cycle of requests, advance the model, sample 1ns after the edge.
    task automatic step(input logic r, input logic w, input logic [7:0] d);
        bit acc_r;
        bit acc_w;
        acc_r = r && (q.size() != 0);
        acc_w = w && (q.size() != 16);
        rd = r;
        wr = w;
        data_in = d;
        @(posedge clk);
        #1;
        if (acc_r) m_dout = q.pop_front();
        if (acc_w) q.push_back(d);
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        m_dout = 8'h00;
        n_cmp++;
        if (empty !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_empty: got %b want 1", empty);
        end
        n_cmp++;
        if (full !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_full: got %b want 0", full);
        end
        n_cmp++;
        if (data_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_data_out: got %h want 00", data_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_ordering();
        logic [7:0] exp_v [3];
        exp_v[0] = 8'h11;
        exp_v[1] = 8'h22;
        exp_v[2] = 8'h33;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, exp_v[i]);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'h00);
            n_cmp++;
            if (data_out !== exp_v[i]) begin
                n_bad++;
                $display("FAIL order_read%0d: got %h want %h", i, data_out, exp_v[i]);
            end
        end
        n_cmp++;
        if (empty !== 1'b1) begin
            n_bad++;
            $display("FAIL order_empty: got %b want 1", empty);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (full !== 1'b0) begin
                n_bad++;
                $display("FAIL fill_not_full%0d: got %b want 0", i, full);
            end
            step(1'b0, 1'b1, 8'(i));
        end
        n_cmp++;
        if (full !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_full: got %b want 1", full);
        end
        step(1'b0, 1'b1, 8'hAA);
        n_cmp++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            n_bad++;
            $display("FAIL overflow_flags: got full=%b empty=%b want 1/0", full, empty);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'h00);
            n_cmp++;
            if (data_out !== 8'(i)) begin
                n_bad++;
                $display("FAIL drain%0d: got %h want %h", i, data_out, 8'(i));
            end
        end
        n_cmp++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_flags: got full=%b empty=%b want 0/1", full, empty);
        end
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'h00);
            n_cmp++;
            if (data_out !== 8'h0F || empty !== 1'b1) begin
                n_bad++;
                $display("FAIL underflow%0d: got data=%h empty=%b want 0f/1", i, data_out,
                         empty);
            end
        end
        // A count that drifted below zero would show up here as non-empty after one read.
        step(1'b0, 1'b1, 8'h77);
        step(1'b1, 1'b0, 8'h00);
        n_cmp++;
        if (data_out !== 8'h77 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL underflow_count: got data=%h empty=%b want 77/1", data_out, empty);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'hA0 + 8'(i));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 8'hB0 + 8'(i));
            n_cmp++;
            if (data_out !== m_dout || q.size() != 5 || empty !== 1'b0 || full !== 1'b0) begin
                n_bad++;
                $display("FAIL simul%0d: got data=%h e=%b f=%b want %h/0/0", i, data_out,
                         empty, full, m_dout);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 8'h00);
            n_cmp++;
            if (data_out !== m_dout) begin
                n_bad++;
                $display("FAIL simul_drain%0d: got %h want %h", i, data_out, m_dout);
            end
        end
        n_cmp++;
        if (empty !== 1'b1) begin
            n_bad++;
            $display("FAIL simul_count: got empty=%b want 1", empty);
        end
    endtask

    task automatic test_simul_empty();
        logic [7:0] held;
        held = m_dout;
        step(1'b1, 1'b1, 8'hC3);
        n_cmp++;
        if (empty !== 1'b0 || data_out !== held) begin
            n_bad++;
            $display("FAIL simul_empty: got empty=%b data=%h want 0/%h", empty, data_out, held);
        end
        step(1'b1, 1'b0, 8'h00);
        n_cmp++;
        if (data_out !== 8'hC3 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL simul_empty_read: got data=%h empty=%b want c3/1", data_out, empty);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h40 + 8'(i));
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        m_dout = 8'h00;
        n_cmp++;
        if (empty !== 1'b1 || data_out !== 8'h00) begin
            n_bad++;
            $display("FAIL midreset_async: got empty=%b data=%h want 1/00", empty, data_out);
        end
        #2;
        rst = 1'b0;
        step(1'b0, 1'b1, 8'h5C);
        step(1'b1, 1'b0, 8'h00);
        n_cmp++;
        if (data_out !== 8'h5C || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_rw: got data=%h empty=%b want 5c/1", data_out, empty);
        end
    endtask

    task automatic test_random();
        logic       r;
        logic       w;
        logic [7:0] d;
        // Start near full so both boundaries get exercised.
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 8'($urandom));
        for (int i = 0; i < 20; i++) begin
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            step(r, w, d);
            n_cmp++;
            if (data_out !== m_dout || empty !== (q.size() == 0) || full !== (q.size() == 16))
            begin
                n_bad++;
                $display("FAIL random%0d: got data=%h e=%b f=%b want %h/%b/%b (size %0d)", i,
                         data_out, empty, full, m_dout, q.size() == 0, q.size() == 16,
                         q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_fill_overflow();
        test_underflow();
        test_simultaneous();
        test_simul_empty();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sync_fifo
